data_mem_lsu: RTL

- Parametrised byte-addressed data memory with load/store unit front end for the RISC-V core.
- Successor to the single-cycle word-only data memory. Adds:
  - byte, half and word accesses, with load sign or zero extension;
  - misalignment detection;
  - a valid/ready request handshake with configurable wait states;
  - a registered response.
- Sits between the core's MEM stage and the stall logic; rsp_valid releases the stall.

---
 rtl/data_mem_lsu.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with a load/store front end: byte/half/word
// accesses, misalignment and range checks, valid/ready request, registered response.
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WORD_AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;

    logic               accept;
    logic [WORD_AW-1:0] word_idx;
    logic [1:0]         lane;
    logic               f3_legal;
    logic               misaligned;
    logic               out_of_range;
    logic               req_err;
    logic               wr_en;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic [31:0]        rd_word;

    logic [2:0]         f3_reg;
    logic [1:0]         lane_reg;
    logic               we_reg;
    logic               err_reg;

    logic               rsp_valid_reg;
    logic [31:0]        rsp_rdata_reg;
    logic               rsp_err_reg;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_data;

    assign word_idx = req_addr[WORD_AW+1:2];
    assign lane     = req_addr[1:0];

    // Any address bit above the memory span means the access is out of range.
    generate
        if (ADDR_W > WORD_AW + 2) begin : g_range
            assign out_of_range = |req_addr[ADDR_W-1:WORD_AW+2];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    // Request decode: legality, alignment, byte enables and lane-replicated store data.
    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        wr_be      = 4'b0000;
        wr_data    = req_wdata;
        case (req_funct3)
            3'b000: begin
                f3_legal = 1'b1;
                wr_be    = 4'b0001 << lane;
                wr_data  = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                f3_legal   = 1'b1;
                misaligned = lane[0];
                wr_be      = lane[1] ? 4'b1100 : 4'b0011;
                wr_data    = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                f3_legal   = 1'b1;
                misaligned = |lane;
                wr_be      = 4'b1111;
            end
            3'b100, 3'b101: begin
                // Unsigned variants exist only for loads.
                f3_legal   = ~req_we;
                misaligned = req_funct3[0] & lane[0];
            end
            default: begin
                f3_legal = 1'b0;
            end
        endcase
    end

    assign req_err   = ~f3_legal | misaligned | out_of_range;
    assign req_ready = (state_reg == ST_IDLE);
    assign accept    = req_valid & req_ready & ~rst;
    assign wr_en     = accept & req_we & ~req_err;

    // One byte-wide RAM per lane so byte enables map onto independent arrays.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    mem[word_idx] <= wr_data[8*gi +: 8];
                end
                if (accept) begin
                    rd_q <= mem[word_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (accept) begin
            f3_reg   <= req_funct3;
            lane_reg <= lane;
            we_reg   <= req_we;
            err_reg  <= req_err;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign byte_sel = rd_word[8*lane_reg +: 8];
    assign half_sel = lane_reg[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'd0;
        case (f3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase
        if (we_reg || err_reg) begin
            load_data = 32'd0;
        end
    end

    // The response is registered out of RESP; data/err hold between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rsp_valid_reg <= (state_reg == ST_RESP);
            if (state_reg == ST_RESP) begin
                rsp_rdata_reg <= load_data;
                rsp_err_reg   <= err_reg;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
